// File: rtl/cache_dm_wb_if.sv
// Bus bundle between a CPU, the direct-mapped cache and the line-burst adaptor.
// The cache side uses the slave modport; the environment driving it uses master.
interface cache_dm_wb_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_wmask;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic [255:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_wdata, pmem_read, pmem_write
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_wdata, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_dm_wb.sv
// Direct-mapped, write-back, write-allocate cache with 32-byte lines.
// Each set holds valid, dirty, tag and a full 256-bit line in flops.
// A miss on a dirty line writes the victim back before filling; after a fill
// the FSM returns to CHECK so the access then completes as an ordinary hit.
module cache_dm_wb #(
  parameter int S_INDEX = 3
) (
  input logic          clk,
  input logic          rst,
  cache_dm_wb_if.slave bus
);

  localparam int NUM_SETS = 1 << S_INDEX;
  localparam int TAG_W    = 27 - S_INDEX;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] WB    = 2'd2;
  localparam logic [1:0] FILL  = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
  logic [255:0]        line_arr [NUM_SETS];

  logic [S_INDEX-1:0]  index;
  logic [TAG_W-1:0]    req_tag;
  logic [2:0]          word;
  logic [7:0]          word_offset;
  logic [255:0]        cur_line;
  logic [31:0]         cur_word;
  logic [31:0]         merged_word;
  logic                hit;
  logic                is_write;
  logic                write_hit;
  logic                fill_done;

  assign index       = bus.mem_address[S_INDEX+4:5];
  assign req_tag     = bus.mem_address[31:S_INDEX+5];
  assign word        = bus.mem_address[4:2];
  assign word_offset = {word, 5'b0};
  assign cur_line    = line_arr[index];
  assign cur_word    = cur_line[word_offset +: 32];

  // A simultaneous read and write request is serviced as a write.
  assign is_write  = bus.mem_write;
  assign hit       = valid[index] && (tag_arr[index] == req_tag);
  assign write_hit = (state == CHECK) && hit && is_write;
  assign fill_done = (state == FILL) && bus.pmem_resp;

  // Byte-merge the CPU write data into the currently addressed word.
  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_wmask[b]) begin
        merged_word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
      end
    end
  end

  // Next-state logic: hits finish in CHECK, misses go through WB and/or FILL.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (hit) begin
          state_next = IDLE;
        end else if (valid[index] && dirty[index]) begin
          state_next = WB;
        end else begin
          state_next = FILL;
        end
      end
      WB: begin
        if (bus.pmem_resp) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (bus.pmem_resp) begin
          state_next = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any line transfer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Per-set valid/dirty bookkeeping: fills produce clean lines, write hits dirty them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_done) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (write_hit) begin
      dirty[index] <= 1'b1;
    end
  end

  // Tag and line storage; not reset, and never written while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        line_arr[index] <= bus.pmem_rdata;
        tag_arr[index]  <= req_tag;
      end else if (write_hit) begin
        line_arr[index][word_offset +: 32] <= merged_word;
      end
    end
  end

  assign bus.mem_resp     = (state == CHECK) && hit;
  assign bus.mem_rdata    = cur_word;
  assign bus.pmem_read    = (state == FILL);
  assign bus.pmem_write   = (state == WB);
  assign bus.pmem_wdata   = cur_line;
  assign bus.pmem_address = (state == WB) ? {tag_arr[index], index, 5'b0}
                                          : {bus.mem_address[31:5], 5'b0};

endmodule

// File: tb/tb_cache_dm_wb.sv
// Scoreboard bench for cache_dm_wb: directed CPU accesses push expected
// responses and expected line transfers into queues; independent monitors
// pop and compare whenever the cache answers the CPU or starts a transfer.
module tb_cache_dm_wb;

  localparam int RESP_LATENCY = 5;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    string       name;
  } cpu_exp_t;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    int          word;
    logic [31:0] wword;
    string       name;
  } pmem_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;
  bit   resp_enable = 1'b1;

  cpu_exp_t     cpu_q[$];
  pmem_exp_t    pmem_q[$];
  logic [255:0] mem_model [logic [31:0]];

  cache_dm_wb_if bus();

  cache_dm_wb #(.S_INDEX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic cpu_exp_t mkCpu(input bit is_read, input logic [31:0] rdata,
                                     input string name);
    cpu_exp_t e;
    e.is_read = is_read;
    e.rdata   = rdata;
    e.name    = name;
    return e;
  endfunction

  function automatic pmem_exp_t mkPmem(input bit is_write, input logic [31:0] addr,
                                       input int word, input logic [31:0] wword,
                                       input string name);
    pmem_exp_t e;
    e.is_write = is_write;
    e.addr     = addr;
    e.word     = word;
    e.wword    = wword;
    e.name     = name;
    return e;
  endfunction

  task automatic loadLine(input logic [31:0] addr, input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) begin
      l[i*32 +: 32] = base + 32'(i);
    end
    mem_model[addr] = l;
  endtask

  // Issue one CPU access, hold it until mem_resp, and report cycles to response.
  task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [3:0] wmask, input logic [31:0] wdata,
                               input string name, output int lat);
    bit got;
    @(posedge clk);
    #1;
    bus.mem_address = addr;
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.mem_wmask   = wmask;
    bus.mem_wdata   = wdata;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_resp === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Line-memory model: answers each transfer RESP_LATENCY cycles after it starts.
  initial begin
    int count;
    count = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      if (!rst && resp_enable && (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1)) begin
        count++;
        if (count == RESP_LATENCY) begin
          if (bus.pmem_write === 1'b1) begin
            mem_model[bus.pmem_address] = bus.pmem_wdata;
          end else if (mem_model.exists(bus.pmem_address)) begin
            bus.pmem_rdata = mem_model[bus.pmem_address];
          end else begin
            bus.pmem_rdata = '0;
          end
          bus.pmem_resp = 1'b1;
          count = 0;
        end
      end else begin
        count = 0;
      end
    end
  end

  // CPU-side monitor: every mem_resp pulse consumes one expected response.
  initial begin
    forever begin
      cpu_exp_t e;
      @(negedge clk);
      if (!rst && bus.mem_resp === 1'b1) begin
        if (cpu_q.size() == 0) begin
          checkOutput("unexpected_mem_resp", 32'd1, 32'd0);
        end else begin
          e = cpu_q.pop_front();
          if (e.is_read) checkOutput(e.name, bus.mem_rdata, e.rdata);
        end
      end
    end
  end

  // Line-side monitor: each new transfer consumes one expectation; held ones must stay put.
  initial begin
    logic        prev_rd;
    logic        prev_wr;
    logic [31:0] held_addr;
    prev_rd   = 1'b0;
    prev_wr   = 1'b0;
    held_addr = '0;
    forever begin
      pmem_exp_t e;
      @(negedge clk);
      if (rst) begin
        prev_rd = 1'b0;
        prev_wr = 1'b0;
      end else begin
        if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
          checkOutput("pmem_exclusive", {31'b0, bus.pmem_read & bus.pmem_write}, 32'd0);
        end
        if ((bus.pmem_read && !prev_rd) || (bus.pmem_write && !prev_wr)) begin
          held_addr = bus.pmem_address;
          if (pmem_q.size() == 0) begin
            checkOutput("unexpected_pmem_request", bus.pmem_address, 32'hFFFF_FFFF);
          end else begin
            e = pmem_q.pop_front();
            checkOutput({e.name, "_is_write"}, {31'b0, bus.pmem_write}, {31'b0, e.is_write});
            checkOutput({e.name, "_addr"}, bus.pmem_address, e.addr);
            if (e.is_write) begin
              checkOutput({e.name, "_wdata"}, bus.pmem_wdata[e.word*32 +: 32], e.wword);
            end
          end
        end else if (bus.pmem_read || bus.pmem_write) begin
          checkOutput("pmem_addr_stable", bus.pmem_address, held_addr);
        end
        prev_rd = bus.pmem_read;
        prev_wr = bus.pmem_write;
      end
    end
  end

  // Directed sequence.
  initial begin
    int  lat;
    bit  seen;
    logic [255:0] l;
    rst             = 1'b1;
    bus.mem_address = '0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wmask   = '0;
    bus.mem_wdata   = '0;

    loadLine(32'h0000_0100, 32'h0100_0000);
    l = mem_model[32'h0000_0100];
    l[63:32] = 32'hDEAD_BEEF;
    mem_model[32'h0000_0100] = l;
    loadLine(32'h0001_0100, 32'hA000_0000);
    loadLine(32'h0002_0100, 32'hB000_0000);
    loadLine(32'h0003_0100, 32'hC000_0000);
    loadLine(32'h0000_00E0, 32'h0E00_0000);
    loadLine(32'h0004_00E0, 32'h4000_0000);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_resp",   {31'b0, bus.mem_resp},   32'd0);
    checkOutput("reset_pmem_read",  {31'b0, bus.pmem_read},  32'd0);
    checkOutput("reset_pmem_write", {31'b0, bus.pmem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] read miss after reset fills the line");
    pmem_q.push_back(mkPmem(1'b0, 32'h0000_0100, 0, 32'h0, "t1_fill"));
    cpu_q.push_back(mkCpu(1'b1, 32'hDEAD_BEEF, "t1_rdata"));
    applyStimulus(32'h0000_0104, 1'b1, 1'b0, 4'h0, 32'h0, "t1", lat);

    $display("[TB] partial write hit then read back");
    cpu_q.push_back(mkCpu(1'b0, 32'h0, "t2_write"));
    applyStimulus(32'h0000_0104, 1'b0, 1'b1, 4'b0011, 32'h1234_5678, "t2w", lat);
    checkOutput("t2_write_hit_latency", 32'(lat), 32'd2);
    cpu_q.push_back(mkCpu(1'b1, 32'hDEAD_5678, "t2_readback"));
    applyStimulus(32'h0000_0104, 1'b1, 1'b0, 4'h0, 32'h0, "t2r", lat);
    checkOutput("t2_read_hit_latency", 32'(lat), 32'd2);

    $display("[TB] conflict miss on dirty line writes back then fills");
    pmem_q.push_back(mkPmem(1'b1, 32'h0000_0100, 1, 32'hDEAD_5678, "t3_wb"));
    pmem_q.push_back(mkPmem(1'b0, 32'h0001_0100, 0, 32'h0, "t3_fill"));
    cpu_q.push_back(mkCpu(1'b1, 32'hA000_0001, "t3_rdata"));
    applyStimulus(32'h0001_0104, 1'b1, 1'b0, 4'h0, 32'h0, "t3", lat);

    $display("[TB] conflict miss on clean line fills directly");
    pmem_q.push_back(mkPmem(1'b0, 32'h0002_0100, 0, 32'h0, "t4_fill"));
    cpu_q.push_back(mkCpu(1'b1, 32'hB000_0002, "t4_rdata"));
    applyStimulus(32'h0002_0108, 1'b1, 1'b0, 4'h0, 32'h0, "t4", lat);

    $display("[TB] write hit with empty byte mask still dirties the line");
    cpu_q.push_back(mkCpu(1'b0, 32'h0, "t5_write"));
    applyStimulus(32'h0002_0108, 1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF, "t5w", lat);
    checkOutput("t5_write_hit_latency", 32'(lat), 32'd2);
    cpu_q.push_back(mkCpu(1'b1, 32'hB000_0002, "t5_readback"));
    applyStimulus(32'h0002_0108, 1'b1, 1'b0, 4'h0, 32'h0, "t5r", lat);

    $display("[TB] read+write together acts as write-allocate write");
    pmem_q.push_back(mkPmem(1'b1, 32'h0002_0100, 2, 32'hB000_0002, "t6_wb"));
    pmem_q.push_back(mkPmem(1'b0, 32'h0003_0100, 0, 32'h0, "t6_fill"));
    cpu_q.push_back(mkCpu(1'b0, 32'h0, "t6_write"));
    applyStimulus(32'h0003_0100, 1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, "t6w", lat);
    cpu_q.push_back(mkCpu(1'b1, 32'hCAFE_F00D, "t6_readback_w0"));
    applyStimulus(32'h0003_0100, 1'b1, 1'b0, 4'h0, 32'h0, "t6r0", lat);
    cpu_q.push_back(mkCpu(1'b1, 32'hC000_0001, "t6_readback_w1"));
    applyStimulus(32'h0003_0104, 1'b1, 1'b0, 4'h0, 32'h0, "t6r1", lat);

    $display("[TB] highest index set");
    pmem_q.push_back(mkPmem(1'b0, 32'h0000_00E0, 0, 32'h0, "t7_fill"));
    cpu_q.push_back(mkCpu(1'b1, 32'h0E00_0000, "t7_rdata"));
    applyStimulus(32'h0000_00E0, 1'b1, 1'b0, 4'h0, 32'h0, "t7", lat);

    $display("[TB] reset in the middle of a fill");
    resp_enable = 1'b0;
    pmem_q.push_back(mkPmem(1'b0, 32'h0004_00E0, 0, 32'h0, "t8_fill_aborted"));
    @(posedge clk);
    #1;
    bus.mem_address = 32'h0004_00E0;
    bus.mem_read    = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.pmem_read === 1'b1) seen = 1'b1;
    end
    checkOutput("t8_fill_started", {31'b0, seen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t8_pmem_read_drops", {31'b0, bus.pmem_read}, 32'd0);
    checkOutput("t8_pmem_write_low",  {31'b0, bus.pmem_write}, 32'd0);
    bus.mem_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_enable = 1'b1;

    pmem_q.push_back(mkPmem(1'b0, 32'h0004_00E0, 0, 32'h0, "t8_refill"));
    cpu_q.push_back(mkCpu(1'b1, 32'h4000_0000, "t8_rdata"));
    applyStimulus(32'h0004_00E0, 1'b1, 1'b0, 4'h0, 32'h0, "t8", lat);
    checkOutput("t8_missed_again", {31'b0, (lat > 2)}, 32'd1);
    pmem_q.push_back(mkPmem(1'b0, 32'h0003_0100, 0, 32'h0, "t8_invalidated"));
    cpu_q.push_back(mkCpu(1'b1, 32'hC000_0000, "t8_invalidated_rdata"));
    applyStimulus(32'h0003_0100, 1'b1, 1'b0, 4'h0, 32'h0, "t8b", lat);

    repeat (3) @(posedge clk);
    checkOutput("cpu_queue_drained",  32'(cpu_q.size()),  32'd0);
    checkOutput("pmem_queue_drained", 32'(pmem_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_dm_wb.md
CACHE_DM_WB -- requirements
Module: cache_dm_wb

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, meaning the number of index bits (2**S_INDEX sets, 32-byte lines).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mem_address  input  32  CPU byte address; bits [1:0] ignored.
REQ-005 SHALL have port mem_read  input  1  CPU read request, held until mem_resp.
REQ-006 SHALL have port mem_write  input  1  CPU write request, held until mem_resp.
REQ-007 SHALL have port mem_wmask  input  4  byte enables for mem_wdata.
REQ-008 SHALL have port mem_wdata  input  32  CPU write data.
REQ-009 SHALL have port mem_rdata  output  32  CPU read data, valid while mem_resp=1.
REQ-010 SHALL have port mem_resp  output  1  one-cycle completion pulse to CPU.
REQ-011 SHALL have port pmem_address  output  32  line address to the burst adaptor, bits [4:0]=0.
REQ-012 SHALL have port pmem_rdata  input  256  fill line from the burst adaptor.
REQ-013 SHALL have port pmem_wdata  output  256  writeback line to the burst adaptor.
REQ-014 SHALL have port pmem_read  output  1  line read request, held until pmem_resp.
REQ-015 SHALL have port pmem_write  output  1  line write request, held until pmem_resp.
REQ-016 SHALL have port pmem_resp  input  1  one-cycle line-transfer completion.

Function
REQ-017 SHALL be direct-mapped write-back write-allocate; index=mem_address[S_INDEX+4:5], tag=mem_address[31:S_INDEX+5] (24 bits at default), word=mem_address[4:2].
REQ-018 SHALL hold per set: valid bit, dirty bit, tag, 256-bit line, all in flops.
REQ-019 SHALL implement states IDLE, CHECK, WB, FILL; next state registered on clk.
REQ-020 SHALL go IDLE->CHECK when mem_read or mem_write is 1; otherwise stay IDLE.
REQ-021 SHALL, in CHECK, define hit as valid[index] and tag match.
REQ-022 SHALL, in CHECK on hit, assert mem_resp=1 for exactly that cycle and go to IDLE; hit latency is 2 cycles from request assertion.
REQ-023 SHALL, on read hit, drive mem_rdata = line[index] bits [word*32+31 : word*32].
REQ-024 SHALL, on write hit, update only bytes enabled by mem_wmask at clock edge and set dirty[index]=1, including when mem_wmask=0.
REQ-025 SHALL treat mem_read and mem_write both 1 as a write.
REQ-026 SHALL, in CHECK on miss, go to WB if valid and dirty, else FILL.
REQ-027 SHALL, in WB, drive pmem_write=1, pmem_address={stored tag, index, 5'b0}, pmem_wdata=line[index]; on pmem_resp go to FILL.
REQ-028 SHALL, in FILL, drive pmem_read=1, pmem_address={mem_address[31:5], 5'b0}; on pmem_resp capture pmem_rdata into line, set valid=1, dirty=0, tag=request tag, go to CHECK.
REQ-029 SHALL never assert pmem_read and pmem_write in the same cycle, and SHALL keep pmem_address stable while either is high.
REQ-030 SHALL drive mem_resp=0, pmem_read=0, pmem_write=0 in all states not listed as asserting them; mem_rdata is don't-care when mem_resp=0.
REQ-031 SHALL hold WB or FILL indefinitely while pmem_resp=0; pmem_resp outside WB/FILL is ignored.

Reset
REQ-032 SHALL, on rst=1 asynchronously, set state=IDLE, all valid=0, all dirty=0, mem_resp=0, pmem_read=0, pmem_write=0.
REQ-033 SHALL abandon any WB/FILL in progress on reset without writing the line array; tags and line data need not reset.

Verification
REQ-034 Read 0x0000_0104 after reset, pmem_resp after 5 cycles with line word1=0xDEADBEEF -> pmem_read with pmem_address=0x0000_0100, then mem_resp with mem_rdata=0xDEADBEEF, no pmem_write.
REQ-035 Write 0x0000_0104 wmask=4'b0011 data=0x1234_5678 after REQ-034 -> mem_resp 2 cycles after request, no pmem activity; read back gives 0xDEAD5678.
REQ-036 Read 0x0001_0104 (same index, new tag) after REQ-035 -> pmem_write at 0x0000_0100 with pmem_wdata word1=0xDEAD5678, then pmem_read at 0x0001_0100, then mem_resp.
REQ-037 Miss on clean line -> FILL directly, pmem_write never asserted.
REQ-038 Assert rst mid-FILL -> pmem_read drops immediately; subsequent read of same address misses again.
